rvmem_arbiter: RTL and testbench

- Arbitrates a single unified memory port between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage RV32I pipeline.
- Sequences one outstanding transaction at a time over a req/gnt/rvalid memory handshake.
- Returns per-requester acks and generates stall_if/stall_dm, which feed the hazard unit's StallF/StallD/StallE/StallM.
- Data requests have priority, because the load/store belongs to the older instruction.

---
 rtl/rvmem_pkg.sv | 7 +
 rtl/rvmem_arbiter_if.sv | 40 ++++
 rtl/rvmem_streak_ctr.sv | 18 +
 rtl/rvmem_arbiter.sv | 86 ++++++++
 tb/tb_rvmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvmem_pkg.sv
// rvmem_pkg: shared FSM/owner types and default widths for the memory-port arbiter
package rvmem_pkg;
  localparam int RV_AW = 32;
  localparam int RV_DW = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/rvmem_arbiter_if.sv
// rvmem_arbiter_if: fetch, data-memory and unified-memory handshake bundle
interface rvmem_arbiter_if import rvmem_pkg::*; #(
  parameter int AW = RV_AW,
  parameter int DW = RV_DW
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;
  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW/8-1:0] dm_be;
  logic [DW-1:0]   dm_rdata;
  logic            dm_ack;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            stall_if;
  logic            stall_dm;
  logic            stray_rvalid;
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr,
           mem_wdata, mem_be, stall_if, stall_dm, stray_rvalid
  );
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr,
           mem_wdata, mem_be, stall_if, stall_dm, stray_rvalid
  );
endinterface

// File: rtl/rvmem_streak_ctr.sv
// rvmem_streak_ctr: counts DM grants made while fetch waits; forces an IF grant at MAX
module rvmem_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_if_req,
  input  logic i_dm_grant,
  input  logic i_if_grant,
  output logic o_force_if
);
  logic [2:0] r_streak;
  assign o_force_if = r_streak == 3'(MAX);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_streak <= '0;
    else if (i_if_grant | ~i_if_req) r_streak <= '0;
    else if (i_dm_grant & ~o_force_if) r_streak <= r_streak + 3'd1;
endmodule

// File: rtl/rvmem_arbiter.sv
// rvmem_arbiter: one-outstanding arbiter of the unified memory port, DM over IF.
// Define RVMEM_ARB_STARVE_EN to bound consecutive DM grants while fetch waits.
module rvmem_arbiter import rvmem_pkg::*; #(
  parameter int AW = RV_AW,
  parameter int DW = RV_DW
`ifdef RVMEM_ARB_STARVE_EN
  , parameter int MAX_DSTREAK = 4
`endif
) (
  input logic            clk,
  input logic            reset_n,
  rvmem_arbiter_if.master bus
);
  arb_state_t      r_state;
  owner_t          r_owner;
  logic            r_mem_req, r_mem_we, r_if_ack, r_dm_ack;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic [DW/8-1:0] r_mem_be;
  logic            w_force_if, w_dm_pick, w_if_pick, w_idle, w_done;
  assign w_idle    = r_state == IDLE;
  assign w_dm_pick = bus.dm_req & ~(w_force_if & bus.if_req);
  assign w_if_pick = bus.if_req & ~w_dm_pick;
  assign w_done    = bus.mem_rvalid & (((r_state == ISSUE) & bus.mem_gnt) | (r_state == WAIT));
`ifdef RVMEM_ARB_STARVE_EN
  rvmem_streak_ctr #(.MAX(MAX_DSTREAK)) u_streak (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_if_req   (bus.if_req),
    .i_dm_grant (w_idle & w_dm_pick),
    .i_if_grant (w_idle & w_if_pick),
    .o_force_if (w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif
  // DONE never re-arbitrates: the acked requester still holds req that cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
    end else begin
      r_if_ack <= w_done & (r_owner == OWN_IF);
      r_dm_ack <= w_done & (r_owner == OWN_DM);
      if (w_done & (r_owner == OWN_IF)) r_if_rdata <= bus.mem_rdata;
      if (w_done & (r_owner == OWN_DM) & ~r_mem_we) r_dm_rdata <= bus.mem_rdata;
      case (r_state)
        IDLE: if (w_dm_pick | w_if_pick) begin
          r_state     <= ISSUE;
          r_mem_req   <= 1'b1;
          r_owner     <= w_dm_pick ? OWN_DM : OWN_IF;
          r_mem_we    <= w_dm_pick & bus.dm_we;
          r_mem_addr  <= w_dm_pick ? bus.dm_addr : bus.if_addr;
          r_mem_wdata <= w_dm_pick ? bus.dm_wdata : '0;
          r_mem_be    <= w_dm_pick ? bus.dm_be : '1;
        end
        ISSUE: if (bus.mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= w_done ? DONE : WAIT;
        end
        WAIT: if (w_done) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_be       = r_mem_be;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.dm_rdata     = r_dm_rdata;
  assign bus.if_ack       = r_if_ack;
  assign bus.dm_ack       = r_dm_ack;
  assign bus.stall_if     = bus.if_req & ~r_if_ack;
  assign bus.stall_dm     = bus.dm_req & ~r_dm_ack;
  assign bus.stray_rvalid = bus.mem_rvalid & (w_idle | ((r_state == ISSUE) & ~bus.mem_gnt));
endmodule

// File: tb/tb_rvmem_arbiter.sv
// tb_rvmem_arbiter: directed bench with a memory responder and per-requester ack scoreboard
module tb_rvmem_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;
`ifdef RVMEM_ARB_STARVE_EN
  localparam logic [5:0] IF_SLOT = 6'b010000;
`else
  localparam logic [5:0] IF_SLOT = 6'b000000;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  int checks = 0, errors = 0;
  int gnt_dly = 0, rv_dly = 1, wcnt = 0, rv_cnt = 0, base = 0;
  logic [31:0] rd_q = '0;
  logic [31:0] mm [logic [31:0]];
  logic [31:0] q_if[$], q_dm[$];
  logic [5:0]  slot;
  txn_t iss[$];

  rvmem_arbiter_if bus();
  rvmem_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(logic [31:0] a);
    return mm.exists(a) ? mm[a] : ~a;
  endfunction

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mm[a] = w;
  endtask

  // memory responder: gnt after gnt_dly wait cycles, rvalid rv_dly cycles after gnt
  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      step();
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = rd_q;
        end
      end
      if (bus.mem_req) begin
        if (wcnt < gnt_dly) wcnt++;
        else begin
          wcnt = 0;
          bus.mem_gnt = 1'b1;
          iss.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be});
          if (bus.mem_we) begin
            wr(bus.mem_addr, bus.mem_wdata, bus.mem_be);
            rd_q = 32'hA5A5A5A5;
          end else rd_q = rd(bus.mem_addr);
          if (rv_dly == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = rd_q;
          end else rv_cnt = rv_dly;
        end
      end
    end
  end

  // scoreboard: every ack pops the oldest expectation of its requester
  always @(negedge clk) begin
    if (bus.if_ack) begin
      chk("if_ack_expected", 32'(q_if.size() != 0), 32'd1);
      if (q_if.size() != 0) chk("if_rdata", bus.if_rdata, q_if.pop_front());
    end
    if (bus.dm_ack) begin
      chk("dm_ack_expected", 32'(q_dm.size() != 0), 32'd1);
      if (q_dm.size() != 0) chk("dm_rdata", bus.dm_rdata, q_dm.pop_front());
    end
  end

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    mm[32'h100] = 32'h00500093;
    mm[32'h2000] = 32'hDEADBEEF;
    repeat (2) step();
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_acks", {bus.if_ack, bus.dm_ack}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
    step();
    reset_n = 1'b1;
    step();

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    q_if.push_back(32'h00500093);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t1_stall_if", bus.stall_if, 32'(c <= 2));
      chk("t1_mem_req", bus.mem_req, 32'(c == 1));
      chk("t1_if_ack", bus.if_ack, 32'(c == 3));
      step();
      if (c == 3) bus.if_req = 1'b0;
    end
    chk("t1_iss_n", iss.size(), 1);
    chk("t1_addr", iss[0].addr, 32'h100);
    chk("t1_be", iss[0].be, 4'hf);
    chk("t1_we", iss[0].we, 0);

    // contention: DM first, then IF
    step();
    base = iss.size();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    q_dm.push_back(32'hDEADBEEF);
    q_if.push_back(32'h00500093);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("t2_dm_ack", bus.dm_ack, 32'(c == 3));
      chk("t2_if_ack", bus.if_ack, 32'(c == 7));
      chk("t2_mem_req", bus.mem_req, 32'(c == 1 || c == 5));
      chk("t2_stall_dm", bus.stall_dm, 32'(c <= 2));
      step();
      if (c == 3) bus.dm_req = 1'b0;
      if (c == 7) bus.if_req = 1'b0;
    end
    chk("t2_iss_n", iss.size(), base + 2);
    chk("t2_first", iss[base].addr, 32'h2000);
    chk("t2_second", iss[base+1].addr, 32'h100);

    // store against a slow grant; dm_rdata keeps the previous load value
    step();
    gnt_dly = 2;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2004;
    bus.dm_wdata = 32'h12345678; bus.dm_be = 4'b0011;
    q_dm.push_back(32'hDEADBEEF);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t3_dm_ack", bus.dm_ack, 32'(c == 5));
      chk("t3_mem_req", bus.mem_req, 32'(c >= 1 && c <= 3));
      if (bus.mem_req) begin
        chk("t3_addr", bus.mem_addr, 32'h2004);
        chk("t3_wdata", bus.mem_wdata, 32'h12345678);
        chk("t3_be", bus.mem_be, 4'b0011);
        chk("t3_we", bus.mem_we, 1);
      end
      step();
      if (c == 5) begin bus.dm_req = 1'b0; bus.dm_we = 1'b0; end
    end
    gnt_dly = 0;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2004; bus.dm_be = 4'h0;
    q_dm.push_back(32'hFFFF5678);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_load_ack", bus.dm_ack, 32'(c == 3));
      step();
      if (c == 3) bus.dm_req = 1'b0;
    end

    // asynchronous reset while in WAIT, then a late rvalid
    step();
    rv_dly = 4;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    step();
    step();
    #2;
    chk("t4_pre_addr", bus.mem_addr, 32'h300);
    chk("t4_pre_req", bus.mem_req, 0);
    reset_n = 1'b0;
    bus.if_req = 1'b0;
    #1;
    chk("t4_addr", bus.mem_addr, 0);
    chk("t4_be", bus.mem_be, 0);
    chk("t4_rdata", bus.if_rdata | bus.dm_rdata, 0);
    chk("t4_req_we", {bus.mem_req, bus.mem_we}, 0);
    step();
    reset_n = 1'b1;
    rv_dly = 1;
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      chk("t4_acks", {bus.if_ack, bus.dm_ack}, 0);
      chk("t4_mem_req", bus.mem_req, 0);
      chk("t4_stray", bus.stray_rvalid, 32'(c == 5));
      step();
    end
    chk("t4_if_rdata", bus.if_rdata, 0);

    // fetch flushed during WAIT still completes exactly once
    step();
    base = iss.size();
    rv_dly = 3;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    q_if.push_back(32'h00500093);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("t5_if_ack", bus.if_ack, 32'(c == 5));
      chk("t5_mem_req", bus.mem_req, 32'(c == 1));
      chk("t5_stall_if", bus.stall_if, 32'(c <= 1));
      step();
      if (c == 1) bus.if_req = 1'b0;
    end
    chk("t5_iss_n", iss.size(), base + 1);

    // gnt and rvalid in the same cycle
    rv_dly = 0;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2000;
    q_dm.push_back(32'hDEADBEEF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_dm_ack", bus.dm_ack, 32'(c == 2));
      chk("t6_mem_req", bus.mem_req, 32'(c == 1));
      step();
      if (c == 2) bus.dm_req = 1'b0;
    end
    rv_dly = 1;

    // both requests held: grant order depends on the starvation guard
    step();
    base = iss.size();
    slot = IF_SLOT;
    for (int i = 0; i < 6; i++)
      if (slot[i]) q_if.push_back(32'h00500093);
      else q_dm.push_back(32'hDEADBEEF);
    q_if.push_back(32'h00500093);
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 100 && iss.size() < base + 6; k++) step();
    chk("t7_six_grants", iss.size(), base + 6);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.dm_ack) break;
    end
    chk("t7_dm_ack_seen", bus.dm_ack, 1);
    step();
    bus.dm_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.if_ack) break;
    end
    chk("t7_if_ack_seen", bus.if_ack, 1);
    step();
    bus.if_req = 1'b0;
    step();
    chk("t7_iss_n", iss.size(), base + 7);
    for (int i = 0; i < 7; i++)
      if (i < 6 && slot[i] == 1'b0) chk("t7_order", iss[base+i].addr, 32'h2000);
      else chk("t7_order", iss[base+i].addr, 32'h100);

    repeat (3) step();
    chk("q_if_drained", q_if.size(), 0);
    chk("q_dm_drained", q_dm.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
